// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register: valid/ready handshake over a main + skid entry pair.
// Optional stall statistics counter enabled by defining PIPE_REG_STATS_EN.
module exe_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic              in_mem_w_en,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_val_rm,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_val_rm,
    output logic [DEST_W-1:0] out_dest
`ifdef PIPE_REG_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] val_rm;
        logic [DEST_W-1:0] dest;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   in_ready_q;
    logic   main_v;
    logic   accept;
    logic   pop;

    // Killed entries keep their data; only the side-effecting control bits drop.
    function automatic entry_t kill_ctrl(input entry_t e);
        entry_t r;
        r          = e;
        r.wb_en    = 1'b0;
        r.mem_r_en = 1'b0;
        r.mem_w_en = 1'b0;
        return r;
    endfunction

    assign in_entry = '{
        wb_en:    in_wb_en,
        mem_r_en: in_mem_r_en,
        mem_w_en: in_mem_w_en,
        alu_res:  in_alu_res,
        val_rm:   in_val_rm,
        dest:     in_dest
    };

    assign main_v = (state_q != EMPTY);
    assign accept = in_valid && in_ready_q;
    assign pop    = main_v && out_ready;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // A concurrent pop already completed on the MEM side; nothing survives.
            state_d = EMPTY;
            main_d  = kill_ctrl(main_q);
            skid_d  = kill_ctrl(skid_q);
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = TWO;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = main_v;
    assign out_wb_en    = main_v & main_q.wb_en;
    assign out_mem_r_en = main_v & main_q.mem_r_en;
    assign out_mem_w_en = main_v & main_q.mem_w_en;
    assign out_alu_res  = main_q.alu_res;
    assign out_val_rm   = main_q.val_rm;
    assign out_dest     = main_q.dest;

`ifdef PIPE_REG_STATS_EN
    logic [STAT_W-1:0] stall_q;

    // Saturating count of cycles MEM holds off a presented entry; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (main_v && !out_ready && (stall_q != {STAT_W{1'b1}})) begin
            stall_q <= stall_q + STAT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    localparam int unused_stat_w = STAT_W;
`endif

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Randomised + directed bench for exe_mem_pipe_reg against a queue-based model.
// Define PIPE_REG_STATS_EN to also check the stall counter (including a STAT_W=2 copy).
module tb_exe_mem_pipe_reg;

    localparam int DW = 32;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_wb_en = 1'b0;
    logic          in_mem_r_en = 1'b0;
    logic          in_mem_w_en = 1'b0;
    logic [DW-1:0] in_alu_res = '0;
    logic [DW-1:0] in_val_rm = '0;
    logic [RW-1:0] in_dest = '0;
    logic          out_ready = 1'b0;

    logic          in_ready;
    logic          out_valid;
    logic          out_wb_en;
    logic          out_mem_r_en;
    logic          out_mem_w_en;
    logic [DW-1:0] out_alu_res;
    logic [DW-1:0] out_val_rm;
    logic [RW-1:0] out_dest;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef PIPE_REG_STATS_EN
    logic [15:0]   stall_cnt;
    logic [1:0]    stall_cnt_s2;
    logic          s2_in_ready, s2_out_valid, s2_wb, s2_r, s2_w;
    logic [DW-1:0] s2_alu, s2_vrm;
    logic [RW-1:0] s2_dest;
`endif

    exe_mem_pipe_reg #(.DATA_W(DW), .DEST_W(RW), .STAT_W(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
        .in_alu_res(in_alu_res), .in_val_rm(in_val_rm), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
        .out_alu_res(out_alu_res), .out_val_rm(out_val_rm), .out_dest(out_dest)
`ifdef PIPE_REG_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

`ifdef PIPE_REG_STATS_EN
    exe_mem_pipe_reg #(.DATA_W(DW), .DEST_W(RW), .STAT_W(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s2_in_ready),
        .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
        .in_alu_res(in_alu_res), .in_val_rm(in_val_rm), .in_dest(in_dest),
        .out_valid(s2_out_valid), .out_ready(out_ready),
        .out_wb_en(s2_wb), .out_mem_r_en(s2_r), .out_mem_w_en(s2_w),
        .out_alu_res(s2_alu), .out_val_rm(s2_vrm), .out_dest(s2_dest),
        .stall_cnt(stall_cnt_s2)
    );
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries.
    typedef struct {
        logic          wb;
        logic          r;
        logic          w;
        logic [DW-1:0] alu;
        logic [DW-1:0] vrm;
        logic [RW-1:0] dest;
    } ent_t;

    ent_t q[$];
    ent_t m_new;
    int   exp_stall = 0;
    int   exp_stall2 = 0;
    bit   m_acc;
    bit   m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            exp_stall  = 0;
            exp_stall2 = 0;
        end else begin
            m_acc = in_valid && (q.size() < 2);
            m_pop = (q.size() > 0) && out_ready;
            if ((q.size() > 0) && !out_ready) begin
                if (exp_stall < 65535) exp_stall++;
                if (exp_stall2 < 3) exp_stall2++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_acc) begin
                    m_new = '{wb: in_wb_en, r: in_mem_r_en, w: in_mem_w_en,
                              alu: in_alu_res, vrm: in_val_rm, dest: in_dest};
                    q.push_back(m_new);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", in_ready, q.size() < 2);
            check("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                check("out_wb_en", out_wb_en, q[0].wb);
                check("out_mem_r_en", out_mem_r_en, q[0].r);
                check("out_mem_w_en", out_mem_w_en, q[0].w);
                check("out_alu_res", out_alu_res, q[0].alu);
                check("out_val_rm", out_val_rm, q[0].vrm);
                check("out_dest", out_dest, q[0].dest);
            end else begin
                check("bubble_ctrl", {out_wb_en, out_mem_r_en, out_mem_w_en}, 3'b000);
            end
`ifdef PIPE_REG_STATS_EN
            check("stall_cnt", stall_cnt, exp_stall);
            check("stall_cnt_s2", stall_cnt_s2, exp_stall2);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic wb, input logic r, input logic w,
                       input logic [DW-1:0] alu, input logic [RW-1:0] dest);
        in_valid    = v;
        in_wb_en    = wb;
        in_mem_r_en = r;
        in_mem_w_en = w;
        in_alu_res  = alu;
        in_val_rm   = alu ^ 32'hA5A5_0000;
        in_dest     = dest;
    endtask

    initial begin
        #12 rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_alu", out_alu_res, 32'h0);
        check("rst_dest", out_dest, 4'h0);

`ifdef PIPE_REG_STATS_EN
        out_ready = 1'b0;
        put(1, 1, 0, 0, 32'h77, 4'd7);
        step();
        put(0, 0, 0, 0, 32'h0, 4'd0);
        repeat (5) step();
        check("stats_5", stall_cnt, 16'd5);
        repeat (5) step();
        check("stats_10", stall_cnt, 16'd10);
        check("stats_sat", stall_cnt_s2, 2'd3);
        out_ready = 1'b1;
        step();
`endif

        // Stream: back-to-back, one cycle latency, ready stays high.
        out_ready = 1'b1;
        put(1, 1, 0, 0, 32'h10, 4'd1);
        step();
        check("stream_a_valid", out_valid, 1'b1);
        check("stream_a_alu", out_alu_res, 32'h10);
        check("stream_a_dest", out_dest, 4'd1);
        put(1, 1, 0, 0, 32'h20, 4'd2);
        step();
        check("stream_b_alu", out_alu_res, 32'h20);
        check("stream_b_ready", in_ready, 1'b1);
        put(1, 1, 0, 0, 32'h30, 4'd3);
        step();
        check("stream_c_alu", out_alu_res, 32'h30);
        check("stream_c_dest", out_dest, 4'd3);
        put(0, 0, 0, 0, 32'h0, 4'd0);
        step();
        check("stream_drain", out_valid, 1'b0);

        // Skid fill: two entries with MEM stalled, then drain in order.
        out_ready = 1'b0;
        put(1, 0, 1, 0, 32'h11, 4'd4);
        step();
        check("skid_a_ready", in_ready, 1'b1);
        check("skid_a_alu", out_alu_res, 32'h11);
        put(1, 0, 1, 0, 32'h22, 4'd5);
        step();
        check("skid_full_ready", in_ready, 1'b0);
        check("skid_hold_alu", out_alu_res, 32'h11);
        put(0, 0, 0, 0, 32'h0, 4'd0);
        out_ready = 1'b1;
        step();
        check("skid_b_alu", out_alu_res, 32'h22);
        check("skid_ready_back", in_ready, 1'b1);
        step();
        check("skid_empty", out_valid, 1'b0);

        // Flush in TWO with a concurrent accept attempt.
        out_ready = 1'b0;
        put(1, 0, 0, 1, 32'h44, 4'd6);
        step();
        put(1, 0, 0, 1, 32'h55, 4'd7);
        step();
        put(1, 0, 0, 1, 32'h33, 4'd8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        put(0, 0, 0, 0, 32'h0, 4'd0);
        check("flush_valid", out_valid, 1'b0);
        check("flush_mem_w", out_mem_w_en, 1'b0);
        check("flush_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        step();
        check("flush_no_c", out_valid, 1'b0);

        // Pop coinciding with flush in ONE.
        out_ready = 1'b0;
        put(1, 1, 0, 0, 32'h66, 4'd9);
        step();
        put(0, 0, 0, 0, 32'h0, 4'd0);
        out_ready = 1'b1;
        flush = 1'b1;
        check("popflush_pre_valid", out_valid, 1'b1);
        check("popflush_pre_alu", out_alu_res, 32'h66);
        step();
        flush = 1'b0;
        check("popflush_empty", out_valid, 1'b0);

        // Asynchronous reset between edges while streaming.
        out_ready = 1'b1;
        put(1, 1, 0, 0, 32'h88, 4'd10);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_alu", out_alu_res, 32'h0);
        check("arst_wb", out_wb_en, 1'b0);
        check("arst_ready", in_ready, 1'b1);
        put(0, 0, 0, 0, 32'h0, 4'd0);
        #3 rst = 1'b0;
        check("arst_rel_ready", in_ready, 1'b1);
        check("arst_rel_valid", out_valid, 1'b0);
        step();

        // Randomised traffic with occasional flushes and MEM stalls.
        for (int i = 0; i < 600; i++) begin
            put($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom, 4'($urandom));
            in_val_rm = $urandom;
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step();
        end
        put(0, 0, 0, 0, 32'h0, 4'd0);
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_mem_pipe_reg.md
Name: exe_mem_pipe_reg

Overview:
Parametrised EXE→MEM pipeline register with valid/ready handshake and a 2-entry skid buffer. It replaces the fixed enable/clear stage register, so the EXE stage can keep issuing one cycle past a MEM-side stall without losing data. It carries the WB/MEM control bits, the ALU result, the store value (Val_Rm) and the destination register index. A synchronous flush kills in-flight entries.

Parameters:
DATA_W, 32, width of the ALU result and Val_Rm fields
DEST_W, 4, width of the destination register index
STAT_W, 16, width of the stall counter (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous kill of all held entries (branch taken / exception)
in_valid  in  1  EXE presents a valid entry
in_ready  out  1  stage can accept; registered, equals !skid_valid
in_wb_en  in  1  write-back enable
in_mem_r_en  in  1  memory read enable
in_mem_w_en  in  1  memory write enable
in_alu_res  in  DATA_W  ALU result / memory address
in_val_rm  in  DATA_W  store data
in_dest  in  DEST_W  destination register
out_valid  out  1  entry presented to MEM
out_ready  in  1  MEM accepts the entry
out_wb_en, out_mem_r_en, out_mem_w_en  out  1 each  control bits of the head entry
out_alu_res  out  DATA_W  head ALU result
out_val_rm  out  DATA_W  head store data
out_dest  out  DEST_W  head destination
stall_cnt  out  STAT_W  stall cycle count (present only with PIPE_REG_STATS_EN)

Behaviour:
- Storage: main register (drives outputs directly, no combinational path from in_* to out_*) plus a skid register. Valid bits: main_v, skid_v.
- Reset: all valid bits, control bits, data fields and stall_cnt = 0. After reset: in_ready = 1, out_valid = 0.
- Handshake: accept = in_valid && in_ready; pop = out_valid && out_ready. out_valid = main_v. Out fields are stable while out_valid && !out_ready.
- States and transitions:
  - EMPTY (main_v=0, skid_v=0): accept → ONE. Entry loads into main.
  - ONE (main_v=1, skid_v=0):
    - accept && pop → ONE, main reloads.
    - accept && !pop → TWO, entry goes to skid.
    - !accept && pop → EMPTY.
    - otherwise hold.
  - TWO (main_v=1, skid_v=1): in_ready = 0. pop → ONE, skid moves to main, skid_v=0. Otherwise hold.
- Ordering: strict FIFO. Latency: accept at edge N gives out_valid at N+1 when empty. Throughput: 1 entry/cycle when out_ready is held high.
- Flush (highest priority after rst): next edge sets main_v = skid_v = 0 and zeros all control bits (wb/mem_r/mem_w) in both entries. Data fields hold their values. An accept in the same cycle is discarded. A pop in the same cycle still completes (MEM already sampled it).
- out_* control bits are forced to 0 whenever main_v = 0, so a bubble never writes memory or the register file.
- Reset mid-operation: asynchronous clear to the reset values above; in-flight entries are lost.

Optional Feature:
- Macro: PIPE_REG_STATS_EN.
- Defined: port stall_cnt exists. It increments each cycle with out_valid && !out_ready and saturates at 2^STAT_W-1. Cleared only by rst; flush does not clear it.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Stream: out_ready=1, send alu_res 0x10,0x20,0x30 with dest 1,2,3 on back-to-back cycles → same values at the outputs one cycle later, back-to-back, in_ready stays 1.
- Skid fill: send A=0x11 and B=0x22 with out_ready=0 → cycle 2 in_ready=0 and out holds A. Raise out_ready → A then B pop in order, in_ready returns to 1 one cycle after the first pop.
- Flush: TWO state holding entries with mem_w_en=1, assert flush together with in_valid (C=0x33) → next cycle out_valid=0 and out_mem_w_en=0. C never appears.
- Pop+flush: ONE state with out_ready=1 and flush=1 → the entry is counted as consumed in that cycle, EMPTY next cycle.
- Async reset: assert rst mid-stream between clock edges → outputs zero immediately. After release in_ready=1 and out_valid=0.
- Stats (PIPE_REG_STATS_EN): hold out_ready=0 for 5 cycles with a valid entry → stall_cnt=5. With STAT_W=2, hold 10 cycles → stall_cnt=3.
